nibble_serial_add_ctrl: RTL
===========================

// Module: nibble_serial_add_ctrl
//
// PURPOSE
// Sequencer that reuses a single 4-bit ripple-carry slice across a wide operand.
// The slice is four fulladd cells with an external carry-in. The block accepts
// a WIDTH-bit add request, feeds one nibble per clock, and holds the carry
// between nibbles. It returns the (WIDTH+1)-bit sum over a valid/ready handshake.
// Sits between operand producers and consumers that cannot afford a WIDTH-bit adder.
//
// PARAMETERS
// WIDTH  16  operand width in bits; must be a multiple of 4 and >= 4
// (localparam NIB = WIDTH/4 = nibbles per operation; IDXW = clog2(NIB), minimum 1)
//
// PORTS
// clk        in   1          single clock, all state on rising edge
// rst        in   1          synchronous reset, active-high
// in_valid   in   1          request: a/b valid
// in_ready   out  1          block can accept a request
// a          in   WIDTH      operand A, unsigned
// b          in   WIDTH      operand B, unsigned
// out_valid  out  1          sum valid
// out_ready  in   1          consumer accepts sum
// sum        out  WIDTH+1    A+B; sum[WIDTH] is the final carry
// busy       out  1          operation in progress (state != IDLE)
//
// BEHAVIOUR
// - Reset (rst=1 at edge), from any state including mid-RUN:
//   state=IDLE, idx=0, carry=0, sum=0, out_valid=0, operand regs=0.
// - in_ready = (state==IDLE) && !rst. busy = (state!=IDLE).
//   Both are combinational from state.
// - FSM transitions:
//   IDLE: on in_valid && in_ready, capture a/b into shift regs, set carry=0,
//         set idx=0, go to RUN. The first slice carry-in is 0 (no carry-in port).
//   RUN:  each edge, the slice adds opA[3:0] + opB[3:0] + carry.
//         Write the 4-bit result into sum[4*idx+3 : 4*idx] and the carry-out
//         into carry. Shift the operand regs right by 4 and increment idx.
//         When idx==NIB-1, also write the carry-out to sum[WIDTH] and go to DONE.
//   DONE: out_valid=1. When out_ready=1, go to IDLE and clear out_valid.
//         sum keeps its value until the next accept.
// - Latency: out_valid rises exactly NIB edges after the accept edge.
//   Throughput is one op per NIB+2 cycles minimum (no IDLE bypass).
// - a/b are sampled only at the accept edge. Later changes have no effect.
// - in_valid in RUN/DONE is ignored (in_ready=0); the requester must hold it.
// - sum bits for nibbles not yet written hold their previous value. Only the DONE
//   contents are defined.
// - out_ready while not in DONE is ignored.
// - Arithmetic: unsigned; sum == a + b exactly, including a=b=2^WIDTH-1.
// - WIDTH not a multiple of 4: configuration error, not supported.
//
// TESTING
// T1 WIDTH=4: a=4'b1001, b=4'b0111, in_valid for 1 cycle ->
//    out_valid 1 edge later, sum=5'b10000.
// T2 WIDTH=16: a=16'hFFFF, b=16'h0001 -> out_valid 4 edges after accept,
//    sum=17'h10000 (carry ripples through all nibbles).
// T3 WIDTH=16: a=16'hFFFF, b=16'hFFFF; hold out_ready=0 for 6 cycles ->
//    sum=17'h1FFFE stable, out_valid=1, in_ready=0 throughout.
//    One cycle after out_ready=1: in_ready=1.
// T4 WIDTH=16: accept a=16'h1234, b=16'h4321, then change a/b on the next cycle ->
//    sum=17'h05555.
// T5 WIDTH=16: assert rst for 1 cycle during RUN (idx=2) ->
//    next cycle state IDLE, out_valid=0, sum=0, in_ready=1.
//    A new request a=1, b=2 then gives sum=3.
// T6 WIDTH=8: 500 random back-to-back requests with random out_ready ->
//    every sum == a+b, in order, none lost or duplicated.

Source files
------------

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
//   Adds two WIDTH-bit unsigned operands with one shared 4-bit ripple-carry slice.
//   Each clock feeds one nibble of each operand through the slice. The carry is
//   held in a register between nibbles. The (WIDTH+1)-bit sum is returned over a
//   valid/ready handshake.
//
// Ports
//   i_clk        clock; all state changes on the rising edge
//   i_rst        synchronous reset, active-high
//   i_in_valid   request: i_a/i_b are valid
//   o_in_ready   a request can be accepted (idle and not in reset)
//   i_a, i_b     WIDTH-bit unsigned operands, sampled only at the accept edge
//   o_out_valid  o_sum holds a complete result
//   i_out_ready  consumer takes the result
//   o_sum        i_a + i_b; o_sum[WIDTH] is the final carry
//   o_busy       an operation is in progress
module nibble_serial_add_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH:0]   o_sum,
  output logic             o_busy
);

  localparam int unsigned NIB  = WIDTH / 4;
  localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and at least 4");
  end

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [IDXW-1:0]  r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH:0]   r_sum;

  logic             w_accept;
  logic             w_last;
  logic [3:0]       w_slice_sum;
  logic             w_slice_cout;
  logic [IDXW+1:0]  w_base;

  // Four full-adder cells in a ripple chain; the chain carry is a local
  // variable so the slice is a plain combinational cone.
  always_comb begin
    logic c;
    c           = r_carry;
    w_slice_sum = '0;
    for (int i = 0; i < 4; i++) begin
      w_slice_sum[i] = r_op_a[i] ^ r_op_b[i] ^ c;
      c              = (r_op_a[i] & r_op_b[i]) | (c & (r_op_a[i] ^ r_op_b[i]));
    end
    w_slice_cout = c;
  end

  assign o_in_ready  = (r_state == StIdle) && !i_rst;
  assign o_busy      = (r_state != StIdle);
  assign o_out_valid = (r_state == StDone);
  assign o_sum       = r_sum;

  assign w_accept = i_in_valid && o_in_ready;
  assign w_last   = (r_idx == IDXW'(NIB - 1));
  // Bit offset of the nibble currently being written.
  assign w_base   = {r_idx, 2'b00};

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept)    w_state_next = StRun;
      StRun:   if (w_last)      w_state_next = StDone;
      StDone:  if (i_out_ready) w_state_next = StIdle;
      default:                  w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_sum   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_op_a  <= i_a;
        r_op_b  <= i_b;
        r_carry <= 1'b0;
        r_idx   <= '0;
      end else if (r_state == StRun) begin
        r_sum[w_base +: 4] <= w_slice_sum;
        r_carry            <= w_slice_cout;
        r_op_a             <= r_op_a >> 4;
        r_op_b             <= r_op_b >> 4;
        r_idx              <= r_idx + 1'b1;
        if (w_last) begin
          r_sum[WIDTH] <= w_slice_cout;
        end
      end
    end
  end

endmodule
